// File: rtl/htif_mem_arbiter_pkg.sv
// Shared definitions for the HTIF/core memory arbiter.
// Requester-side tag width comes from the riscv constant MEM_TAG_BITS.
// Optional build macro: MEMARB_HTIF_PRIO_EN (strict HTIF priority, see top).
`ifndef MEM_TAG_BITS
`define MEM_TAG_BITS 4
`endif

package htif_mem_arbiter_pkg;

    // Requester-side memory tag width
    localparam int MEM_TAG_BITS = `MEM_TAG_BITS;

    // Width of the per-requester outstanding-read counters
    localparam int CNT_W = 4;

    // Requester ID encodings: slot 0 is the HTIF bridge, the rest are core ports
    typedef enum logic [2:0] {
        REQ_HTIF  = 3'd0,
        REQ_CORE0 = 3'd1,
        REQ_CORE1 = 3'd2,
        REQ_CORE2 = 3'd3,
        REQ_CORE3 = 3'd4,
        REQ_CORE4 = 3'd5,
        REQ_CORE5 = 3'd6,
        REQ_CORE6 = 3'd7
    } req_id_e;

    // Lock FSM: OPEN arbitrates freely, LOCKED holds the offered request
    typedef enum logic {
        LOCK_OPEN   = 1'b0,
        LOCK_LOCKED = 1'b1
    } lock_state_e;

endpackage

// File: rtl/htif_mem_arbiter_rr_arbiter.sv
// Round-robin priority search: the first set request at or after ptr wins,
// wrapping explicitly so NUM_REQ need not be a power of two.
module htif_mem_arbiter_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_id,
    output logic               any
);

    // Scan NUM_REQ positions starting at ptr and keep the first hit
    always_comb begin
        int idx;
        grant    = '0;
        grant_id = '0;
        any      = 1'b0;
        idx      = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!any && req[idx]) begin
                any        = 1'b1;
                grant[idx] = 1'b1;
                grant_id   = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/htif_mem_arbiter.sv
// Shares one 128-bit memory port between the HTIF bridge (requester 0) and
// the core refill/writeback ports. Round-robin arbitration, tag extended
// with the requester ID, responses steered back by that ID.
// Optional build macro: MEMARB_HTIF_PRIO_EN gives requester 0 strict
// priority whenever it is eligible and no request is locked.
module htif_mem_arbiter
    import htif_mem_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int TAG_W   = MEM_TAG_BITS,
    parameter int MAX_OUT = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_val,
    output logic [NUM_REQ-1:0]      req_rdy,
    input  logic [NUM_REQ-1:0]      req_op,
    input  logic [NUM_REQ*32-1:0]   req_addr,
    input  logic [NUM_REQ*128-1:0]  req_data,
    input  logic [NUM_REQ*TAG_W-1:0] req_tag,
    output logic [NUM_REQ-1:0]      resp_val,
    output logic [127:0]            resp_data,
    output logic [TAG_W-1:0]        resp_tag,
    output logic                    mem_req_val,
    input  logic                    mem_req_rdy,
    output logic                    mem_req_op,
    output logic [31:0]             mem_req_addr,
    output logic [127:0]            mem_req_data,
    output logic [TAG_W+ID_W-1:0]   mem_req_tag,
    input  logic                    mem_resp_val,
    input  logic [127:0]            mem_resp_data,
    input  logic [TAG_W+ID_W-1:0]   mem_resp_tag,
    output logic                    error
);

    localparam int MEM_TAG_W = TAG_W + ID_W;

    genvar gi;

    lock_state_e                    lock_state_reg;
    lock_state_e                    lock_state_next;
    logic [ID_W-1:0]                lock_id_reg;
    logic [ID_W-1:0]                rr_ptr_reg;
    logic [NUM_REQ-1:0][CNT_W-1:0]  out_cnt;
    logic                           error_reg;

    logic                           lock;
    logic [NUM_REQ-1:0]             eligible;
    logic [NUM_REQ-1:0]             rr_grant;
    logic [ID_W-1:0]                rr_id;
    logic                           rr_any;
    logic [ID_W-1:0]                win_id;
    logic [NUM_REQ-1:0]             win_oh;
    logic                           win_any;
    logic                           prio_win;
    logic                           fire;
    logic [ID_W-1:0]                resp_id;
    logic                           resp_id_ok;
    logic [NUM_REQ-1:0]             resp_hit;
    logic [NUM_REQ-1:0]             cnt_zero_err;
    logic                           err_set;

`ifdef MEMARB_HTIF_PRIO_EN
    localparam int HTIF_IDX = int'(REQ_HTIF);
    // Remembers that the locked request was won through HTIF priority,
    // so its eventual acceptance leaves rr_ptr alone
    logic                           lock_prio_reg;
`endif

    assign lock = (lock_state_reg == LOCK_LOCKED);

    // A read is only eligible while the requester has room for another response
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_elig
        assign eligible[gi] = req_val[gi] &
                              (req_op[gi] | (out_cnt[gi] < CNT_W'(MAX_OUT)));
    end

    htif_mem_arbiter_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr (
        .req      (eligible),
        .ptr      (rr_ptr_reg),
        .grant    (rr_grant),
        .grant_id (rr_id),
        .any      (rr_any)
    );

    // Winner: locked requester first, then (optionally) HTIF, then round-robin
    always_comb begin
        win_id   = rr_id;
        win_oh   = rr_grant;
        win_any  = rr_any;
        prio_win = 1'b0;
        if (lock) begin
            win_id  = lock_id_reg;
            win_oh  = NUM_REQ'(1) << lock_id_reg;
            win_any = req_val[lock_id_reg];
`ifdef MEMARB_HTIF_PRIO_EN
            prio_win = lock_prio_reg;
`endif
        end
`ifdef MEMARB_HTIF_PRIO_EN
        else if (eligible[HTIF_IDX]) begin
            win_id   = ID_W'(HTIF_IDX);
            win_oh   = NUM_REQ'(1) << HTIF_IDX;
            win_any  = 1'b1;
            prio_win = 1'b1;
        end
`endif
    end

    // Request path is a pure mux; outputs are forced quiet while in reset
    assign mem_req_val  = win_any & ~rst;
    assign fire         = mem_req_val & mem_req_rdy;
    assign req_rdy      = win_oh & {NUM_REQ{fire}};
    assign mem_req_op   = req_op[win_id];
    assign mem_req_addr = req_addr[32*int'(win_id) +: 32];
    assign mem_req_data = req_data[128*int'(win_id) +: 128];
    assign mem_req_tag  = {win_id, req_tag[TAG_W*int'(win_id) +: TAG_W]};

    // Lock FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_state_reg <= LOCK_OPEN;
        end else begin
            lock_state_reg <= lock_state_next;
        end
    end

    // Lock when an offer is stalled, release once memory accepts
    always_comb begin
        lock_state_next = lock_state_reg;
        case (lock_state_reg)
            LOCK_OPEN: begin
                if (mem_req_val && !mem_req_rdy) begin
                    lock_state_next = LOCK_LOCKED;
                end
            end
            LOCK_LOCKED: begin
                if (mem_req_rdy) begin
                    lock_state_next = LOCK_OPEN;
                end
            end
            default: lock_state_next = LOCK_OPEN;
        endcase
    end

    // Capture the stalled winner on entry to LOCKED
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_id_reg <= '0;
`ifdef MEMARB_HTIF_PRIO_EN
            lock_prio_reg <= 1'b0;
`endif
        end else if (!lock && lock_state_next == LOCK_LOCKED) begin
            lock_id_reg <= win_id;
`ifdef MEMARB_HTIF_PRIO_EN
            lock_prio_reg <= prio_win;
`endif
        end
    end

    // Advance the round-robin pointer past the accepted requester
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_reg <= '0;
        end else if (fire && !prio_win) begin
            rr_ptr_reg <= (int'(win_id) == NUM_REQ - 1) ? '0 : win_id + 1'b1;
        end
    end

    // Response steering by the ID carried in the upper tag bits
    assign resp_id   = mem_resp_tag[MEM_TAG_W-1:TAG_W];
    assign resp_tag  = mem_resp_tag[TAG_W-1:0];
    assign resp_data = mem_resp_data;
    assign resp_val  = resp_hit & {NUM_REQ{~rst}};

    if ((2 ** ID_W) > NUM_REQ) begin : g_id_chk
        assign resp_id_ok = (int'(resp_id) < NUM_REQ);
    end else begin : g_id_all
        assign resp_id_ok = 1'b1;
    end

    // Per-requester outstanding-read counters
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_cnt
        logic [CNT_W-1:0] cnt_reg;
        logic             cnt_inc;
        logic             cnt_dec;

        assign resp_hit[gi]     = mem_resp_val & (resp_id == ID_W'(gi));
        assign cnt_zero_err[gi] = resp_hit[gi] & (cnt_reg == '0);
        assign cnt_inc          = fire & ~mem_req_op & win_oh[gi];
        assign cnt_dec          = resp_hit[gi];
        assign out_cnt[gi]      = cnt_reg;

        // Count issued reads up, returned responses down; both at once cancel
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt_reg <= '0;
            end else if (cnt_inc && !cnt_dec) begin
                if (cnt_reg < CNT_W'(MAX_OUT)) begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end else if (cnt_dec && !cnt_inc) begin
                if (cnt_reg != '0) begin
                    cnt_reg <= cnt_reg - 1'b1;
                end
            end
        end
    end

    assign err_set = (lock & ~req_val[lock_id_reg]) |
                     (mem_resp_val & ~resp_id_ok) |
                     (|cnt_zero_err);

    // Sticky protocol error, cleared only by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            error_reg <= 1'b0;
        end else if (err_set) begin
            error_reg <= 1'b1;
        end
    end

    assign error = error_reg;

endmodule

// File: tb/tb_htif_mem_arbiter.sv
// Directed bench for htif_mem_arbiter: a vector table for arbitration and
// lock hold, plus short sequences for reset, read limits, routing and errors.
module tb_htif_mem_arbiter;
    import htif_mem_arbiter_pkg::*;

    localparam int NR = 4;
    localparam int IW = 2;
    localparam int TW = MEM_TAG_BITS;

`ifdef MEMARB_HTIF_PRIO_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst;
    logic [NR-1:0]      req_val;
    logic [NR-1:0]      req_rdy;
    logic [NR-1:0]      req_op;
    logic [NR*32-1:0]   req_addr;
    logic [NR*128-1:0]  req_data;
    logic [NR*TW-1:0]   req_tag;
    logic [NR-1:0]      resp_val;
    logic [127:0]       resp_data;
    logic [TW-1:0]      resp_tag;
    logic               mem_req_val;
    logic               mem_req_rdy;
    logic               mem_req_op;
    logic [31:0]        mem_req_addr;
    logic [127:0]       mem_req_data;
    logic [TW+IW-1:0]   mem_req_tag;
    logic               mem_resp_val;
    logic [127:0]       mem_resp_data;
    logic [TW+IW-1:0]   mem_resp_tag;
    logic               error;

    int total = 0;
    int bad   = 0;

    htif_mem_arbiter #(
        .NUM_REQ (NR),
        .ID_W    (IW),
        .TAG_W   (TW),
        .MAX_OUT (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_val       (req_val),
        .req_rdy       (req_rdy),
        .req_op        (req_op),
        .req_addr      (req_addr),
        .req_data      (req_data),
        .req_tag       (req_tag),
        .resp_val      (resp_val),
        .resp_data     (resp_data),
        .resp_tag      (resp_tag),
        .mem_req_val   (mem_req_val),
        .mem_req_rdy   (mem_req_rdy),
        .mem_req_op    (mem_req_op),
        .mem_req_addr  (mem_req_addr),
        .mem_req_data  (mem_req_data),
        .mem_req_tag   (mem_req_tag),
        .mem_resp_val  (mem_resp_val),
        .mem_resp_data (mem_resp_data),
        .mem_resp_tag  (mem_resp_tag),
        .error         (error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NR-1:0] val;
        logic          rdy;
        logic          exp_v;
        int            exp_id;
        int            exp_id_p;
    } vec_t;

    vec_t tbl [16];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end else begin
            $display("ok   %s val=%0h", name, act);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        req_val      = '0;
        req_op       = '0;
        mem_req_rdy  = 1'b0;
        mem_resp_val = 1'b0;
        mem_resp_tag = '0;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        logic [NR-1:0]    exp_rdy;
        logic [TW+IW-1:0] exp_tag;
        int               eid;

        for (int i = 0; i < NR; i++) begin
            req_addr[32*i +: 32]  = 32'h1000_0000 + 32'(i * 16);
            req_data[128*i +: 128] = {4{32'hA5A5_0000 + 32'(i)}};
            req_tag[TW*i +: TW]   = TW'(i + 8);
        end
        mem_resp_data = '0;

        // Reset state with live inputs on every port
        rst          = 1'b1;
        req_val      = 4'b1111;
        req_op       = 4'b0000;
        mem_req_rdy  = 1'b1;
        mem_resp_val = 1'b1;
        mem_resp_tag = {2'd1, 4'h3};
        #1;
        chk("rst_mem_req_val", 128'(mem_req_val), 128'(1'b0));
        chk("rst_req_rdy", 128'(req_rdy), 128'(4'b0000));
        chk("rst_resp_val", 128'(resp_val), 128'(4'b0000));
        chk("rst_error", 128'(error), 128'(1'b0));
        do_reset();

        // Arbitration table: all writes so no counters move
        //            val      rdy  v     rr  prio
        tbl[0]  = '{4'b1111, 1'b1, 1'b1, 0, 0};
        tbl[1]  = '{4'b1111, 1'b1, 1'b1, 1, 0};
        tbl[2]  = '{4'b1111, 1'b1, 1'b1, 2, 0};
        tbl[3]  = '{4'b1111, 1'b1, 1'b1, 3, 0};
        tbl[4]  = '{4'b1111, 1'b1, 1'b1, 0, 0};
        tbl[5]  = '{4'b1111, 1'b1, 1'b1, 1, 0};
        tbl[6]  = '{4'b1111, 1'b1, 1'b1, 2, 0};
        tbl[7]  = '{4'b1111, 1'b1, 1'b1, 3, 0};
        tbl[8]  = '{4'b1010, 1'b1, 1'b1, 1, 1};
        tbl[9]  = '{4'b1001, 1'b1, 1'b1, 3, 0};
        tbl[10] = '{4'b0000, 1'b0, 1'b0, 0, 0};
        tbl[11] = '{4'b0110, 1'b0, 1'b1, 1, 2};
        tbl[12] = '{4'b0111, 1'b0, 1'b1, 1, 2};
        tbl[13] = '{4'b0111, 1'b1, 1'b1, 1, 2};
        tbl[14] = '{4'b0111, 1'b1, 1'b1, 2, 0};
        tbl[15] = '{4'b1000, 1'b1, 1'b1, 3, 3};

        req_op = 4'b1111;
        for (int i = 0; i < 16; i++) begin
            req_val     = tbl[i].val;
            mem_req_rdy = tbl[i].rdy;
            #1;
            eid     = PRIO ? tbl[i].exp_id_p : tbl[i].exp_id;
            exp_rdy = (tbl[i].exp_v && tbl[i].rdy) ? NR'(1) << eid : '0;
            exp_tag = {IW'(eid), TW'(eid + 8)};
            $display("vec %0d val=%b rdy=%b", i, tbl[i].val, tbl[i].rdy);
            chk("tbl_mem_req_val", 128'(mem_req_val), 128'(tbl[i].exp_v));
            chk("tbl_req_rdy", 128'(req_rdy), 128'(exp_rdy));
            if (tbl[i].exp_v) begin
                chk("tbl_mem_req_tag", 128'(mem_req_tag), 128'(exp_tag));
                chk("tbl_mem_req_addr", 128'(mem_req_addr), 128'(32'h1000_0000 + 32'(eid * 16)));
            end
            step();
        end

        // Reset asserted while requester 2 is locked
        do_reset();
        req_op      = 4'b1111;
        req_val     = 4'b0100;
        mem_req_rdy = 1'b0;
        #1 chk("ml_offer_id", 128'(mem_req_tag[5:4]), 128'(2'd2));
        step();
        req_val = 4'b0111;
        #1 chk("ml_locked_id", 128'(mem_req_tag[5:4]), 128'(2'd2));
        mem_req_rdy = 1'b1;
        rst         = 1'b1;
        #1;
        chk("ml_rst_val", 128'(mem_req_val), 128'(1'b0));
        chk("ml_rst_rdy", 128'(req_rdy), 128'(4'b0000));
        step();
        rst = 1'b0;
        #1;
        chk("ml_after_val", 128'(mem_req_val), 128'(1'b1));
        chk("ml_after_id", 128'(mem_req_tag[5:4]), 128'(2'd0));
        step();

        // Outstanding-read limit on requester 3
        do_reset();
        req_val     = 4'b1000;
        req_op      = 4'b0000;
        mem_req_rdy = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1 chk("lim_rd_grant", 128'(req_rdy), 128'(4'b1000));
            step();
        end
        #1;
        chk("lim_5th_rdy", 128'(req_rdy), 128'(4'b0000));
        chk("lim_5th_val", 128'(mem_req_val), 128'(1'b0));
        req_op = 4'b1000;
        #1 chk("lim_wr_grant", 128'(req_rdy), 128'(4'b1000));
        step();
        req_op       = 4'b0000;
        mem_resp_val = 1'b1;
        mem_resp_tag = {2'd3, 4'h9};
        #1;
        chk("lim_resp_blocked", 128'(req_rdy), 128'(4'b0000));
        chk("lim_resp_route", 128'(resp_val), 128'(4'b1000));
        step();
        mem_resp_val = 1'b0;
        #1 chk("lim_after_resp", 128'(req_rdy), 128'(4'b1000));
        step();
        #1 chk("lim_full_again", 128'(req_rdy), 128'(4'b0000));
        // Free one slot, then fire a read in the same cycle as a response
        mem_resp_val = 1'b1;
        step();
        #1 chk("sim_fire", 128'(req_rdy), 128'(4'b1000));
        step();
        mem_resp_val = 1'b0;
        #1 chk("sim_next", 128'(req_rdy), 128'(4'b1000));
        step();
        #1;
        chk("sim_full", 128'(req_rdy), 128'(4'b0000));
        chk("lim_error", 128'(error), 128'(1'b0));

        // Response routing back to requester 2
        do_reset();
        req_val     = 4'b0100;
        req_op      = 4'b0000;
        mem_req_rdy = 1'b1;
        #1 chk("route_issue", 128'(req_rdy), 128'(4'b0100));
        step();
        req_val       = 4'b0000;
        mem_resp_val  = 1'b1;
        mem_resp_tag  = {2'd2, 4'h5};
        mem_resp_data = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_FACE_B00C;
        #1;
        chk("route_val", 128'(resp_val), 128'(4'b0100));
        chk("route_tag", 128'(resp_tag), 128'(4'h5));
        chk("route_data", resp_data, 128'hDEAD_BEEF_0123_4567_89AB_CDEF_FACE_B00C);
        step();
        mem_resp_val = 1'b0;
        #1 chk("route_error", 128'(error), 128'(1'b0));

        // Unexpected response for requester 1 (nothing outstanding)
        mem_resp_val = 1'b1;
        mem_resp_tag = {2'd1, 4'h0};
        #1 chk("err_before", 128'(error), 128'(1'b0));
        step();
        mem_resp_val = 1'b0;
        #1 chk("err_set", 128'(error), 128'(1'b1));
        repeat (3) step();
        chk("err_sticky", 128'(error), 128'(1'b1));
        rst = 1'b1;
        #1 chk("err_rst", 128'(error), 128'(1'b0));
        step();
        rst = 1'b0;

        // Locked requester withdraws its request
        do_reset();
        req_val     = 4'b0010;
        req_op      = 4'b1111;
        mem_req_rdy = 1'b0;
        step();
        req_val = 4'b0000;
        #1 chk("drop_pending", 128'(error), 128'(1'b0));
        step();
        chk("drop_err", 128'(error), 128'(1'b1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
